detector_jogada: RTL and testbench
==================================

# detector_jogada

Upstream conditioner for the memory-game datapath. Synchronizes the raw `botoes` inputs, debounces press and release, and emits exactly one single-cycle `jogada` pulse per physical press, with the registered button code. Its outputs feed the `botoes`/`tem_jogada` inputs of `jogo_playseq`, replacing the raw switches.

## Interface

**Parameters**
- `N_BOTOES`, default 4: width of the button bus.
- `DEBOUNCE_CYCLES`, default 5: consecutive stable samples required. Legal range is 2 or more; values below 2 are an elaboration error.

**Ports**
- `clock`, in, 1: single system clock, rising edge.
- `reset`, in, 1: asynchronous, active-low; clears all state.
- `botoes`, in, N_BOTOES: raw, asynchronous button levels.
- `jogada`, out, 1: one-cycle pulse, one per accepted press.
- `jogada_valor`, out, N_BOTOES: code of the last accepted press, held until the next accepted press.
- `tem_jogada`, out, 1: high while an accepted press is still held (states PRESSIONADO and SOLTANDO).
- `multiplo`, out, 1: one-cycle pulse when a stable non-one-hot code is rejected. Only exists with the macro defined (see Configuration).
- `db_estado`, out, 3: state encoding, for the 7-segment debug display.

## Operation

**Front end**
- `botoes` passes through a 2-flop synchronizer. `s` denotes the synchronized value.
- The counter `cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits wide and saturates; it never wraps.

**State machine** (`db_estado` encoding in parentheses)
- OCIOSO (0):
  - `s != 0` → FILTRANDO; latch candidate `cand = s`; `cnt = 1`.
- FILTRANDO (1):
  - `s == cand`: `cnt++`. When `cnt == DEBOUNCE_CYCLES-1` and `s == cand` → VALIDO.
  - `s == 0` → OCIOSO.
  - `s != cand` and nonzero → reload `cand = s`, `cnt = 1`, stay in FILTRANDO.
- VALIDO (2): lasts one cycle.
  - `jogada = 1`; `jogada_valor <= cand`.
  - Then → PRESSIONADO.
- PRESSIONADO (3):
  - `s == 0` → SOLTANDO; `cnt = 1`.
  - Any nonzero `s`, including a changed code, stays in PRESSIONADO. There is no new pulse until a full release.
- SOLTANDO (4):
  - `s == 0`: `cnt++`. When `cnt == DEBOUNCE_CYCLES-1` and `s == 0` → OCIOSO.
  - `s != 0` (bounce) → PRESSIONADO, with no pulse.
- Encodings 5 to 7 are unreachable; if entered, the next state is OCIOSO.

## Timing

**Reset values**
- `jogada`, `jogada_valor`, `tem_jogada`, `multiplo` = 0.
- `db_estado` = 0.
- Synchronizer, `cand` and `cnt` = 0.

**Press latency**
- Let edge 0 be the first rising edge that samples the new stable `botoes` value.
- `jogada` is high for the single cycle following edge `DEBOUNCE_CYCLES+2`.
- `jogada_valor` updates on that same edge.
- With the default of 5, a press held for 10 cycles is accepted; a press held for 4 cycles never is.

**Other timing**
- `tem_jogada` rises one edge after `jogada` and falls on the edge entering OCIOSO.
- The minimum spacing between two `jogada` pulses is `2*DEBOUNCE_CYCLES+1` cycles.
- Reset asserted mid-operation takes effect immediately and asynchronously. A pulse in flight is dropped. After release, the FSM starts in OCIOSO, and a button still held is re-filtered and yields a fresh pulse.

## Configuration

`DETECTOR_JOGADA_MULTI_REJECT_EN`

**Defined**
- On the VALIDO condition, if `cand` is not one-hot, the FSM goes to PRESSIONADO without asserting `jogada`.
- `multiplo` pulses for one cycle, and `jogada_valor` is unchanged.
- The port `multiplo` exists.

**Undefined**
- Any nonzero stable code is accepted and pulsed, including multi-button codes.
- The port `multiplo` is absent.

## Structure

**`jogo_pkg`** holds:
- the `estado_detector_t` enum, 3 bits, with the values above;
- function `eh_one_hot(logic [N-1:0])`;
- constant `DEBOUNCE_DEFAULT = 5`.

**Sub-module `sincronizador`** is a 2-flop, parameterized-width synchronizer with asynchronous active-low reset. It is reused for `jogar` elsewhere.

The FSM and counter live in `detector_jogada` itself.

## Test plan

1. **Reset:** drive reset low mid-FILTRANDO → all outputs 0 and `db_estado` = 0 while reset is low; no pulse afterwards.
2. **Clean press:** `botoes=0001` for 10 cycles, then 0 → exactly one `jogada` pulse, 7 edges after sampling; `jogada_valor=0001`; `tem_jogada` low 6 cycles after release is sampled.
3. **Short and bouncy press:** 4-cycle press of `0010` → no pulse. Then `0100` toggling at 0/1/0 for 3 cycles, then stable for 10 → one pulse, `jogada_valor=0100`.
4. **Release bounce:** a stable press of `1000`, then 0 for 2 cycles, `1000` for 1 cycle, then 0 for 10 → single pulse only; `tem_jogada` stays high through the bounce.
5. **Multiple buttons:** `0011` stable for 10 cycles → pulse with value `0011` when the macro is undefined; with `DETECTOR_JOGADA_MULTI_REJECT_EN`, no `jogada`, a `multiplo` pulse, and `jogada_valor` holds its previous value.
6. **Sequence integration:** the 16-entry press sequence played into `jogo_playseq`, each press held 500 cycles → 16 pulses whose codes match the sequence in order.

Source files
------------

// File: rtl/jogo_pkg.sv
// jogo_pkg
// Shared types and helpers for the memory-game front end.
//   estado_detector_t : state encoding of detector_jogada, also shown on db_estado
//   DEBOUNCE_DEFAULT  : default number of stable samples for the debouncer
//   eh_one_hot()      : true when exactly one bit of the code is set
package jogo_pkg;

    localparam int DEBOUNCE_DEFAULT = 5;

    // Widest button code eh_one_hot() inspects; narrower codes are zero-extended.
    localparam int ONE_HOT_MAX_W = 32;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        FILTRANDO   = 3'd1,
        VALIDO      = 3'd2,
        PRESSIONADO = 3'd3,
        SOLTANDO    = 3'd4
    } estado_detector_t;

    // A nonzero value with no second bit set: v & (v-1) clears the lowest set bit.
    function automatic logic eh_one_hot(input logic [ONE_HOT_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/detector_jogada_sincronizador.sv
// sincronizador
// Two-flop synchronizer for asynchronous level inputs.
//   clock : system clock, rising edge
//   reset : asynchronous, active-low; clears both stages
//   d     : raw asynchronous input (WIDTH bits)
//   q     : synchronized output, two clock edges behind d
module sincronizador #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; the second stage gives it a full cycle to settle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/detector_jogada.sv
// detector_jogada
// Synchronizes and debounces the raw button bus and emits one single-cycle
// jogada pulse per physical press, together with the accepted button code.
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-low; clears all state
//   botoes       : raw asynchronous button levels (N_BOTOES bits)
//   jogada       : one-cycle pulse per accepted press
//   jogada_valor : code of the last accepted press, held until the next one
//   tem_jogada   : high while an accepted press is still held
//   multiplo     : one-cycle pulse when a stable multi-button code is rejected
//                  (present only with DETECTOR_JOGADA_MULTI_REJECT_EN defined)
//   db_estado    : current state encoding for the debug display
// Optional feature macro: DETECTOR_JOGADA_MULTI_REJECT_EN
module detector_jogada
    import jogo_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                jogada,
    output logic [N_BOTOES-1:0] jogada_valor,
    output logic                tem_jogada,
`ifdef DETECTOR_JOGADA_MULTI_REJECT_EN
    output logic                multiplo,
`endif
    output logic [2:0]          db_estado
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_debounce_invalid
            $error("detector_jogada: DEBOUNCE_CYCLES must be 2 or more");
        end
    endgenerate

    estado_detector_t    estado;
    logic [N_BOTOES-1:0] s;
    logic [N_BOTOES-1:0] cand;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;

    sincronizador #(
        .WIDTH (N_BOTOES)
    ) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (s)
    );

    // Saturating increment so a long stable level can never wrap the counter.
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign db_estado = estado;

    // Debounce FSM. The debounce window is judged on the count before the
    // increment, so VALIDO is reached after DEBOUNCE_CYCLES synchronized samples
    // and the pulse itself is registered on the edge that leaves VALIDO.
    // tem_jogada is set from PRESSIONADO, so it trails jogada by one edge, and is
    // cleared on the very edge that returns to OCIOSO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            cand         <= '0;
            cnt          <= '0;
            jogada       <= 1'b0;
            jogada_valor <= '0;
            tem_jogada   <= 1'b0;
`ifdef DETECTOR_JOGADA_MULTI_REJECT_EN
            multiplo     <= 1'b0;
`endif
        end else begin
            jogada <= 1'b0;
`ifdef DETECTOR_JOGADA_MULTI_REJECT_EN
            multiplo <= 1'b0;
`endif
            case (estado)
                OCIOSO: begin
                    tem_jogada <= 1'b0;
                    if (s != '0) begin
                        cand   <= s;
                        cnt    <= CNT_ONE;
                        estado <= FILTRANDO;
                    end
                end

                FILTRANDO: begin
                    if (s == '0) begin
                        estado <= OCIOSO;
                    end else if (s != cand) begin
                        // A different code restarts the window with the new candidate.
                        cand <= s;
                        cnt  <= CNT_ONE;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt == CNT_LIM) begin
                            estado <= VALIDO;
                        end
                    end
                end

                VALIDO: begin
                    estado <= PRESSIONADO;
`ifdef DETECTOR_JOGADA_MULTI_REJECT_EN
                    if (eh_one_hot(ONE_HOT_MAX_W'(cand))) begin
                        jogada       <= 1'b1;
                        jogada_valor <= cand;
                    end else begin
                        multiplo <= 1'b1;
                    end
`else
                    jogada       <= 1'b1;
                    jogada_valor <= cand;
`endif
                end

                PRESSIONADO: begin
                    // Code changes while held are ignored until a full release.
                    tem_jogada <= 1'b1;
                    if (s == '0) begin
                        cnt    <= CNT_ONE;
                        estado <= SOLTANDO;
                    end
                end

                SOLTANDO: begin
                    if (s != '0) begin
                        estado <= PRESSIONADO;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt == CNT_LIM) begin
                            tem_jogada <= 1'b0;
                            estado     <= OCIOSO;
                        end
                    end
                end

                default: begin
                    tem_jogada <= 1'b0;
                    estado     <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada
// Directed self-checking bench for detector_jogada with default parameters
// (N_BOTOES = 4, DEBOUNCE_CYCLES = 5). Inputs change 1 time unit after a rising
// edge, so the following rising edge is the first one to sample them.
// Follows DETECTOR_JOGADA_MULTI_REJECT_EN when it is defined for the build.
module tb_detector_jogada;

    logic       clock;
    logic       reset;
    logic [3:0] botoes;
    logic       jogada;
    logic [3:0] jogada_valor;
    logic       tem_jogada;
    logic [2:0] db_estado;
`ifdef DETECTOR_JOGADA_MULTI_REJECT_EN
    logic       multiplo;
    int         multi_count = 0;
`endif

    int         compare_count  = 0;
    int         mismatch_count = 0;
    int         pulse_count    = 0;
    logic [3:0] pulse_values[$];

    detector_jogada #(
        .N_BOTOES        (4),
        .DEBOUNCE_CYCLES (5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes       (botoes),
        .jogada       (jogada),
        .jogada_valor (jogada_valor),
        .tem_jogada   (tem_jogada),
`ifdef DETECTOR_JOGADA_MULTI_REJECT_EN
        .multiplo     (multiplo),
`endif
        .db_estado    (db_estado)
    );

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse monitor on the falling edge, halfway between active edges.
    always @(negedge clock) begin
        if (reset && jogada) begin
            pulse_count++;
            pulse_values.push_back(jogada_valor);
        end
`ifdef DETECTOR_JOGADA_MULTI_REJECT_EN
        if (reset && multiplo) multi_count++;
`endif
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives botoes and lets n rising edges pass, ending 1 unit after the last.
    task automatic applyStimulus(input logic [3:0] value, input int n);
        botoes = value;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    localparam logic [3:0] SEQ [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                        4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                        4'b0100, 4'b0001, 4'b1000, 4'b0010,
                                        4'b0010, 4'b1000, 4'b0001, 4'b0100};

    initial begin
        int         base;
        logic       tem_all_high;
        logic [3:0] valor_antes;

        reset  = 1'b0;
        botoes = 4'b0000;
        #2;
        $display("[TB] reset state");
        checkOutput("reset_jogada", 32'(jogada), 32'd0);
        checkOutput("reset_valor", 32'(jogada_valor), 32'd0);
        checkOutput("reset_tem", 32'(tem_jogada), 32'd0);
        checkOutput("reset_estado", 32'(db_estado), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        applyStimulus(4'b0000, 3);

        // Clean press with edge-accurate latency.
        $display("[TB] clean press");
        base   = pulse_count;
        botoes = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            #1;
            if (k == 2) checkOutput("clean_filtrando", 32'(db_estado), 32'd1);
            if (k == 6) begin
                checkOutput("clean_no_early_pulse", 32'(jogada), 32'd0);
                checkOutput("clean_valido", 32'(db_estado), 32'd2);
            end
            if (k == 7) begin
                checkOutput("clean_pulse", 32'(jogada), 32'd1);
                checkOutput("clean_valor", 32'(jogada_valor), 32'h1);
                checkOutput("clean_tem_late", 32'(tem_jogada), 32'd0);
                checkOutput("clean_pressionado", 32'(db_estado), 32'd3);
            end
            if (k == 8) begin
                checkOutput("clean_pulse_end", 32'(jogada), 32'd0);
                checkOutput("clean_tem_rise", 32'(tem_jogada), 32'd1);
            end
        end
        botoes = 4'b0000;
        for (int r = 0; r < 8; r++) begin
            @(posedge clock);
            #1;
            if (r == 5) checkOutput("release_tem_held", 32'(tem_jogada), 32'd1);
            if (r == 6) begin
                checkOutput("release_tem_fall", 32'(tem_jogada), 32'd0);
                checkOutput("release_ocioso", 32'(db_estado), 32'd0);
            end
        end
        checkOutput("clean_one_pulse", 32'(pulse_count - base), 32'd1);

        // Short press and bouncy press.
        $display("[TB] short and bouncy press");
        base = pulse_count;
        applyStimulus(4'b0010, 4);
        applyStimulus(4'b0000, 10);
        checkOutput("short_no_pulse", 32'(pulse_count - base), 32'd0);
        applyStimulus(4'b0100, 1);
        applyStimulus(4'b0000, 1);
        applyStimulus(4'b0100, 1);
        applyStimulus(4'b0100, 10);
        applyStimulus(4'b0000, 10);
        checkOutput("bouncy_one_pulse", 32'(pulse_count - base), 32'd1);
        checkOutput("bouncy_valor", 32'(jogada_valor), 32'h4);
        checkOutput("bouncy_ocioso", 32'(db_estado), 32'd0);

        // Release bounce: tem_jogada must stay up through the bounce.
        $display("[TB] release bounce");
        base = pulse_count;
        applyStimulus(4'b1000, 10);
        tem_all_high = 1'b1;
        botoes = 4'b0000;
        repeat (2) begin
            @(posedge clock);
            #1;
            tem_all_high &= tem_jogada;
        end
        botoes = 4'b1000;
        @(posedge clock);
        #1;
        tem_all_high &= tem_jogada;
        botoes = 4'b0000;
        repeat (5) begin
            @(posedge clock);
            #1;
            tem_all_high &= tem_jogada;
        end
        applyStimulus(4'b0000, 5);
        checkOutput("bounce_tem_high", 32'(tem_all_high), 32'd1);
        checkOutput("bounce_tem_low_end", 32'(tem_jogada), 32'd0);
        checkOutput("bounce_one_pulse", 32'(pulse_count - base), 32'd1);
        checkOutput("bounce_valor", 32'(jogada_valor), 32'h8);

        // Multi-button code.
        $display("[TB] multiple buttons");
        base        = pulse_count;
        valor_antes = jogada_valor;
`ifdef DETECTOR_JOGADA_MULTI_REJECT_EN
        begin
            int mbase;
            mbase = multi_count;
            applyStimulus(4'b0011, 10);
            applyStimulus(4'b0000, 10);
            checkOutput("multi_no_pulse", 32'(pulse_count - base), 32'd0);
            checkOutput("multi_flag", 32'(multi_count - mbase), 32'd1);
            checkOutput("multi_valor_held", 32'(jogada_valor), 32'(valor_antes));
        end
`else
        applyStimulus(4'b0011, 10);
        applyStimulus(4'b0000, 10);
        checkOutput("multi_pulse", 32'(pulse_count - base), 32'd1);
        checkOutput("multi_valor", 32'(jogada_valor), 32'h3);
        checkOutput("multi_prev_differs", 32'(valor_antes == 4'h3), 32'd0);
`endif

        // Reset mid-filter with the button released during reset.
        $display("[TB] reset mid-operation");
        base = pulse_count;
        applyStimulus(4'b0010, 4);
        reset = 1'b0;
        #2;
        checkOutput("midreset_estado", 32'(db_estado), 32'd0);
        checkOutput("midreset_jogada", 32'(jogada), 32'd0);
        checkOutput("midreset_tem", 32'(tem_jogada), 32'd0);
        checkOutput("midreset_valor", 32'(jogada_valor), 32'd0);
        botoes = 4'b0000;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("midreset_estado_held", 32'(db_estado), 32'd0);
        reset = 1'b1;
        applyStimulus(4'b0000, 12);
        checkOutput("midreset_no_pulse", 32'(pulse_count - base), 32'd0);

        // Reset while the button stays held: a fresh pulse after release of reset.
        applyStimulus(4'b0100, 4);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        applyStimulus(4'b0100, 12);
        applyStimulus(4'b0000, 10);
        checkOutput("held_reset_pulse", 32'(pulse_count - base), 32'd1);
        checkOutput("held_reset_valor", 32'(jogada_valor), 32'h4);

        // Long sequence of presses.
        $display("[TB] press sequence");
        pulse_values.delete();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(SEQ[i], 500);
            applyStimulus(4'b0000, 20);
        end
        checkOutput("seq_count", 32'(pulse_values.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < pulse_values.size()) begin
                checkOutput($sformatf("seq_valor_%0d", i), 32'(pulse_values[i]), 32'(SEQ[i]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
